data_mem_hs: RTL
================

Name: data_mem_hs

Overview:
- Parametrised, handshaked successor to the single-cycle data memory.
- Byte-addressable, big-endian storage with 1/2/4/8-byte transfers.
- Configurable read latency; reports misaligned, out-of-range and illegal-size accesses.
- Sits between the CPU load/store stage and storage, so a multi-cycle/pipelined datapath can stall on memory.

Parameters:
- DATA_W, 64, data width in bits; multiple of 8, max 64.
- ADDR_W, 64, request address width.
- DEPTH_BYTES, 1024, storage size in bytes; power of two.
- READ_LAT, 2, edges from read acceptance to rsp_valid; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  4  transfer bytes: 1, 2, 4 or 8.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  load data, zero-extended.
- rsp_err  out  1  request was illegal; no access performed.

Behaviour:
- Reset (reset_n=0 at an edge):
  - FSM -> IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage contents are not reset.
- Only one request is outstanding at a time. req_ready=1 only in IDLE.
- Acceptance: req_valid & req_ready at an edge. The request fields are captured at that edge.
- Legality checks, evaluated on the accepted request:
  - req_size not in {1,2,4,8}, or req_size*8 > DATA_W -> error.
  - req_addr mod req_size != 0 -> error (misaligned).
  - req_addr + req_size > DEPTH_BYTES, computed without truncation -> error (out of range).
- Error response:
  - No storage access.
  - rsp_valid asserts 1 edge after acceptance with rsp_err=1 and rsp_rdata=0.
- Store:
  - Bytes written at the acceptance edge, big-endian: req_wdata[8*size-1 -: 8] goes to req_addr, least-significant byte goes to req_addr+size-1.
  - Other bytes unchanged.
  - rsp_valid asserts 1 edge after acceptance with rsp_err=0 and rsp_rdata=0.
- Load:
  - Bytes addr..addr+size-1 are assembled big-endian into the low 8*size bits; upper bits are 0.
  - rsp_valid asserts exactly READ_LAT edges after acceptance.
  - Data reflects storage as of the acceptance edge.
- FSM states:
  - IDLE: accept -> WAIT if legal load and READ_LAT>1; otherwise -> RESP.
  - WAIT: latency counter, loaded with READ_LAT-1 at acceptance; -> RESP when the counter reaches 1 (decremented each edge).
  - RESP: rsp_valid=1, outputs stable; -> IDLE on rsp_ready. rsp_valid deasserts on the next edge; the next request cannot be accepted before that edge.
- Back-pressure: in RESP with rsp_ready=0, all rsp_* outputs hold indefinitely.
- Request changes while req_ready=0 are ignored.
- Reset mid-operation (WAIT or RESP):
  - Pending response is discarded and the FSM returns to IDLE.
  - A store already committed at its acceptance edge remains in storage.
- Only the low log2(DEPTH_BYTES) address bits index storage, after the range check passes.

Test Plan:
- Store size 8, addr 0x10, wdata 0x0123456789ABCDEF; then load size 8 at 0x10.
  -> rsp_rdata=0x0123456789ABCDEF, rsp_valid exactly 2 edges after load acceptance, rsp_err=0.
- After the above, load size 1 at 0x10 -> 0x01; load size 2 at 0x16 -> 0xCDEF.
  Then store size 4 at 0x14 with 0xDEADBEEF; load size 8 at 0x10 -> 0x01234567DEADBEEF.
- Illegal requests, each -> rsp_err=1 one edge after acceptance, rsp_rdata=0, and a subsequent load at 0x10 is unchanged:
  - load size 4 at 0x12 (misaligned);
  - store size 8 at 0x3F8+8=0x400 (out of range, DEPTH_BYTES=1024);
  - size 3.
- Back-pressure: load with rsp_ready=0 for 5 cycles.
  -> rsp_valid and rsp_rdata held stable and req_ready=0 throughout; the handshake completes on the first rsp_ready=1 edge; req_ready=1 on the following cycle.
- Reset mid-read: accept a load, drive reset_n=0 one edge later.
  -> no rsp_valid ever seen for that load; req_ready=1 after reset; prior stored data still readable.
- Re-elaborate with READ_LAT=1 and READ_LAT=4; back-to-back loads with rsp_ready=1.
  -> rsp_valid at exactly 1 and 4 edges after each acceptance; one request per READ_LAT+1 cycles.

Source files
------------

// File: rtl/data_mem_hs.sv
// Handshaked byte-addressable big-endian data memory with configurable read latency.
// One request outstanding at a time; illegal requests return an error response with no access.
module data_mem_hs #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned READ_LAT    = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [3:0]        i_req_size,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int unsigned MaxBytes = DATA_W / 8;
  localparam int unsigned IdxW     = $clog2(DEPTH_BYTES);
  localparam int unsigned CntW     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned BaseW    = (ADDR_W > IdxW) ? ADDR_W : IdxW;
  // One spare bit so addr + size never wraps before the range compare.
  localparam int unsigned SumW     = ((BaseW > 8) ? BaseW : 8) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [DATA_W-1:0] r_rdata, w_rdata_d;
  logic              r_err, w_err_d;

  logic [7:0]        r_mem [DEPTH_BYTES];

  logic [SumW-1:0]   w_addr_ext;
  logic [SumW-1:0]   w_end;
  logic [IdxW-1:0]   w_idx;
  int unsigned       w_sz;
  logic              w_size_ok;
  logic              w_misaligned;
  logic              w_oob;
  logic              w_illegal;
  logic              w_accept;
  logic              w_do_store;
  logic [MaxBytes-1:0] w_byte_en;
  logic [7:0]        w_wbyte [MaxBytes];
  logic [DATA_W-1:0] w_load_data;

  assign w_addr_ext   = SumW'(i_req_addr);
  assign w_end        = w_addr_ext + SumW'(i_req_size);
  assign w_idx        = w_addr_ext[IdxW-1:0];
  assign w_sz         = 32'(i_req_size);
  assign w_size_ok    = ((i_req_size == 4'd1) || (i_req_size == 4'd2) ||
                         (i_req_size == 4'd4) || (i_req_size == 4'd8)) &&
                        (32'(i_req_size) * 32'd8 <= DATA_W);
  assign w_misaligned = (w_addr_ext[3:0] & (i_req_size - 4'd1)) != 4'd0;
  assign w_oob        = w_end > SumW'(DEPTH_BYTES);
  assign w_illegal    = !w_size_ok || w_misaligned || w_oob;
  assign w_accept     = i_req_valid && (r_state == StIdle);
  assign w_do_store   = i_reset_n && w_accept && i_req_write && !w_illegal;

  // Byte i of the transfer lives at addr+i and is the (size-1-i)th byte of the data.
  always_comb begin
    w_load_data = '0;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      w_byte_en[i] = (i < w_sz);
      w_wbyte[i]   = 8'(i_req_wdata >> (8 * (w_sz - 1 - i)));
      if (w_byte_en[i]) begin
        w_load_data = (w_load_data << 8) | DATA_W'(r_mem[w_idx + IdxW'(i)]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_store) begin
      for (int unsigned i = 0; i < MaxBytes; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_idx + IdxW'(i)] <= w_wbyte[i];
        end
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rdata_d = r_rdata;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_err_d   = w_illegal;
          w_rdata_d = (w_illegal || i_req_write) ? '0 : w_load_data;
          if (!w_illegal && !i_req_write && (READ_LAT > 1)) begin
            w_state_d = StWait;
            w_cnt_d   = CntW'(READ_LAT - 1);
          end else begin
            w_state_d = StResp;
          end
        end
      end
      StWait: begin
        if (r_cnt == CntW'(1)) begin
          w_state_d = StResp;
        end
        w_cnt_d = r_cnt - CntW'(1);
      end
      StResp: begin
        if (i_rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_rdata <= w_rdata_d;
      r_err   <= w_err_d;
    end
  end

  assign o_req_ready = (r_state == StIdle);
  assign o_rsp_valid = (r_state == StResp);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule
